// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 1 bit/cycle, done XLEN+1 cycles after accept (1 cycle for div-by-zero/overflow).
// Raises stall from accept through the last RUN cycle; flush aborts without touching result.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid_in,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              a_sgn, b_sgn, a_neg, b_neg, neg_in;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic              div_zero, div_ovf;
    logic [XLEN-1:0]   special_res;

    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_acc;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem, div_quo;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, run_res;

    // Operand decode for the instruction presented in IDLE
    always_comb begin
        a_sgn    = (funct3 == 3'b001) | (funct3 == 3'b010) | (funct3 == 3'b100) | (funct3 == 3'b110);
        b_sgn    = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
        a_neg    = a_sgn & a[XLEN-1];
        b_neg    = b_sgn & b[XLEN-1];
        mag_a    = a_neg ? -a : a;
        mag_b    = b_neg ? -b : b;
        // remainder takes the dividend's sign, everything else the XOR
        neg_in   = (funct3[2:1] == 2'b11) ? a_neg : (a_neg ^ b_neg);
        div_zero = funct3[2] & (b == '0);
        div_ovf  = funct3[2] & ~funct3[0] & (a == MIN_NEG) & (b == ALL_ONES);
        if (div_zero) begin
            special_res = funct3[1] ? a : ALL_ONES;
        end else begin
            special_res = funct3[1] ? '0 : a;
        end
    end

    // One iteration of shift-add multiply and restoring divide
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
        mul_acc   = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
        div_shift = {rem_q, acc_q[XLEN-1]};
        div_ge    = div_shift >= {1'b0, opb_q};
        div_rem   = div_ge ? (div_shift[XLEN-1:0] - opb_q) : div_shift[XLEN-1:0];
        div_quo   = {acc_q[XLEN-2:0], div_ge};
        prod_s    = neg_q ? -mul_acc : mul_acc;
        quo_s     = neg_q ? -div_quo : div_quo;
        rem_s     = neg_q ? -div_rem : div_rem;
        case (op_q)
            3'b000:                 run_res = prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: run_res = prod_s[2*XLEN-1:XLEN];
            3'b100, 3'b101:         run_res = quo_s;
            default:                run_res = rem_s;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        rem_d    = rem_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (valid_in) begin
                    op_d  = funct3;
                    neg_d = neg_in;
                    acc_d = {{XLEN{1'b0}}, mag_a};
                    opb_d = mag_b;
                    rem_d = '0;
                    cnt_d = '0;
                    if (div_zero | div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end else begin
                        state_d  = S_RUN;
                    end
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (op_q[2]) begin
                    acc_d = {acc_q[2*XLEN-1:XLEN], div_quo};
                    rem_d = div_rem;
                end else begin
                    acc_d = mul_acc;
                end
                if (cnt_q == CNT_LAST) begin
                    result_d = run_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            rem_q    <= rem_d;
            result_q <= result_d;
        end
    end

    assign stall  = (valid_in & (state_q == S_IDLE)) | (state_q == S_RUN);
    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: a 32-bit and an 8-bit instance checked against a result scoreboard.
module tb_muldiv_unit;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;

    logic        valid32 = 1'b0, flush32 = 1'b0;
    logic [2:0]  funct32 = 3'b000;
    logic [31:0] a32 = '0, b32 = '0;
    logic        stall32, busy32, done32;
    logic [31:0] result32;

    logic        valid8 = 1'b0, flush8 = 1'b0;
    logic [2:0]  funct8 = 3'b000;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        stall8, busy8, done8;
    logic [7:0]  result8;

    int          n_checks = 0;
    int          n_pass = 0;
    sb_t         q32[$];
    sb_t         q8[$];
    logic [31:0] last_exp32 = '0;

    muldiv_unit #(.XLEN(32)) dut32 (
        .clk(clk), .reset(reset), .valid_in(valid32), .funct3(funct32),
        .a(a32), .b(b32), .flush(flush32),
        .stall(stall32), .busy(busy32), .done(done32), .result(result32)
    );

    muldiv_unit #(.XLEN(8)) dut8 (
        .clk(clk), .reset(reset), .valid_in(valid8), .funct3(funct8),
        .a(a8), .b(b8), .flush(flush8),
        .stall(stall8), .busy(busy8), .done(done8), .result(result8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model32(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
        logic signed [63:0] sa, sb, sbu, sp;
        logic        [63:0] up;
        logic signed [31:0] sa32, sb32, sres;
        logic               ovf;
        sa   = {{32{av[31]}}, av};
        sb   = {{32{bv[31]}}, bv};
        sbu  = {32'b0, bv};
        up   = {32'b0, av} * {32'b0, bv};
        sa32 = av;
        sb32 = bv;
        ovf  = (av == 32'h8000_0000) && (bv == 32'hFFFF_FFFF);
        case (op)
            3'b000: model32 = up[31:0];
            3'b001: begin sp = sa * sb;  model32 = sp[63:32]; end
            3'b010: begin sp = sa * sbu; model32 = sp[63:32]; end
            3'b011: model32 = up[63:32];
            3'b100: begin
                if (bv == 0)  model32 = 32'hFFFF_FFFF;
                else if (ovf) model32 = av;
                else begin sres = sa32 / sb32; model32 = sres; end
            end
            3'b101: model32 = (bv == 0) ? 32'hFFFF_FFFF : av / bv;
            3'b110: begin
                if (bv == 0)  model32 = av;
                else if (ovf) model32 = 32'h0;
                else begin sres = sa32 % sb32; model32 = sres; end
            end
            default: model32 = (bv == 0) ? av : av % bv;
        endcase
    endfunction

    // Scoreboard: every done pops the oldest expected result
    always @(negedge clk) begin
        if (done32) begin
            if (q32.size() == 0) begin
                check("dut32_done_without_op", done32, 1'b0);
            end else begin
                sb_t e;
                e = q32.pop_front();
                check(e.tag, result32, e.val);
            end
        end
        if (done8) begin
            if (q8.size() == 0) begin
                check("dut8_done_without_op", done8, 1'b0);
            end else begin
                sb_t e;
                e = q8.pop_front();
                check(e.tag, result8, e.val);
            end
        end
    end

    // Called at posedge+1; valid_in held until done, as the stalled pipeline would
    task automatic run32(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [31:0] exp, input int exp_lat, input string tag);
        int  n;
        bit  seen;
        bit  stall_ok;
        sb_t e;
        e.tag = tag;
        e.val = exp;
        q32.push_back(e);
        last_exp32 = exp;
        valid32 = 1'b1; funct32 = op; a32 = av; b32 = bv;
        n = 0; seen = 0; stall_ok = 1;
        while (!seen && n < 60) begin
            @(negedge clk);
            if (done32) begin
                seen = 1;
                if (stall32) stall_ok = 0;
            end else if (!stall32) begin
                stall_ok = 0;
            end
            if (!seen) begin
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_done_cycle"}, n, exp_lat);
        check({tag, "_stall"}, stall_ok, 1'b1);
        @(posedge clk); #1;
        valid32 = 1'b0;
    endtask

    task automatic run8(input logic [2:0] op, input logic [7:0] av, input logic [7:0] bv,
                        input logic [7:0] exp, input int exp_lat, input string tag);
        int  n;
        bit  seen;
        sb_t e;
        e.tag = tag;
        e.val = {24'b0, exp};
        q8.push_back(e);
        valid8 = 1'b1; funct8 = op; a8 = av; b8 = bv;
        n = 0; seen = 0;
        while (!seen && n < 30) begin
            @(negedge clk);
            if (done8) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        check({tag, "_done_cycle"}, n, exp_lat);
        @(posedge clk); #1;
        valid8 = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] av, bv, prev;
        int          lat;

        // Reset state, with valid_in high so stall must follow it
        valid32 = 1'b1;
        #2;
        check("rst_busy", busy32, 1'b0);
        check("rst_done", done32, 1'b0);
        check("rst_result", result32, 32'h0);
        check("rst_stall", stall32, 1'b1);
        valid32 = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        run32(3'b000, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7_m3");
        run32(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
        run32(3'b011, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulhu_min");
        run32(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_m1");
        run32(3'b100, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 33, "div_m7_2");
        run32(3'b110, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 33, "rem_m7_2");
        run32(3'b101, 32'hFFFF_FFFE, 32'd3,        32'h5555_5554, 33, "divu_big");
        run32(3'b111, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 33, "remu_big");
        run32(3'b101, 32'd5,        32'd0,         32'hFFFF_FFFF, 1,  "divu_by0");
        run32(3'b110, 32'd5,        32'd0,         32'h0000_0005, 1,  "rem_by0");
        run32(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
        run32(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1, "rem_ovf");

        for (int i = 0; i < 8; i++) begin
            op  = 3'($urandom_range(0, 7));
            av  = $urandom;
            bv  = (i == 7) ? 32'h0 : $urandom;
            lat = (op[2] && (bv == 0 || (!op[0] && av == 32'h8000_0000 && bv == 32'hFFFF_FFFF))) ? 1 : 33;
            run32(op, av, bv, model32(op, av, bv), lat, $sformatf("rnd%0d_op%0d", i, op));
        end

        // Flush at cycle 10 of a DIV: back to IDLE, no done, result kept
        prev = last_exp32;
        valid32 = 1'b1; funct32 = 3'b100; a32 = 32'd100; b32 = 32'd7;
        repeat (10) begin @(posedge clk); #1; end
        flush32 = 1'b1; valid32 = 1'b0;
        @(posedge clk); #1;
        flush32 = 1'b0;
        check("flush_busy", busy32, 1'b0);
        check("flush_done", done32, 1'b0);
        check("flush_result", result32, prev);
        repeat (3) begin @(posedge clk); #1; end

        // flush together with valid_in in IDLE blocks the accept
        valid32 = 1'b1; flush32 = 1'b1; funct32 = 3'b000; a32 = 32'd3; b32 = 32'd4;
        @(posedge clk); #1;
        check("flush_blocks_accept", busy32, 1'b0);
        valid32 = 1'b0; flush32 = 1'b0;
        @(posedge clk); #1;

        // Asynchronous reset in the middle of RUN
        valid32 = 1'b1; funct32 = 3'b000; a32 = 32'd3; b32 = 32'd5;
        repeat (5) begin @(posedge clk); #1; end
        check("midrun_busy", busy32, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("arst_busy", busy32, 1'b0);
        check("arst_done", done32, 1'b0);
        check("arst_result", result32, 32'h0);
        check("arst_stall", stall32, 1'b1);
        @(negedge clk);
        reset = 1'b1; valid32 = 1'b0;
        @(posedge clk); #1;

        // XLEN=8 instance
        run8(3'b000, 8'd15,  8'd15,  8'hE1, 9, "x8_mul_15_15");
        repeat (12) begin @(posedge clk); #1; end
        check("x8_idle_after_op", busy8, 1'b0);
        run8(3'b100, 8'h9C, 8'd7,   8'hF2, 9, "x8_div_m100_7");
        run8(3'b110, 8'h9C, 8'd7,   8'hFE, 9, "x8_rem_m100_7");
        run8(3'b100, 8'h80, 8'hFF,  8'h80, 1, "x8_div_ovf");

        repeat (3) begin @(posedge clk); #1; end
        check("sb32_empty", q32.size(), 0);
        check("sb8_empty", q8.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Parametrised iterative multiply/divide unit implementing the eight RV32M operations (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) for an XLEN-wide datapath. It sits in the execute stage beside the ALU. While an operation is in flight it raises a stall request that freezes PC, IF/ID and ID/EX. A flush input aborts the operation when a taken branch in MEM squashes the instruction.

## Interface
- XLEN, 32, operand/result width; any even value ≥ 8.
- CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- valid_in  input  1  execute-stage instruction is an M-extension op; sampled only in IDLE.
- funct3  input  3  RV32M op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand, after forwarding.
- b  input  XLEN  rs2 operand, after forwarding.
- flush  input  1  abort the current operation.
- stall  output  1  combinational: (valid_in & state==IDLE) | state==RUN.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  registered result; holds until the next done.

## Operation
- States:
  - IDLE → RUN on valid_in with a normal operand pair.
  - IDLE → DONE directly on valid_in with a special case (division by zero or signed overflow).
  - RUN → DONE when the counter reaches XLEN.
  - DONE → IDLE unconditionally.
- Accept (IDLE & valid_in):
  - Latch funct3.
  - Take the magnitude of each operand when the op treats it as signed:
    - a is signed for MULH, MULHSU, DIV, REM.
    - b is signed for MULH, DIV, REM.
  - Record the result sign:
    - multiply: sign(a) XOR sign(b), for the signed operands only.
    - quotient: sign(a) XOR sign(b).
    - remainder: sign(a).
  - Clear the counter.
- Multiply, RUN: shift-add, one bit per cycle, over a 2·XLEN accumulator. After XLEN cycles the accumulator holds the unsigned product.
- Divide, RUN: restoring division, one bit per cycle, using an XLEN+1-bit partial remainder. The quotient bit is shifted in on each cycle.
- Entry to DONE:
  - Negate the magnitude result (two's complement) when the recorded sign is 1.
  - MUL selects the low XLEN bits; MULH, MULHSU and MULHU select the high XLEN bits.
  - DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Write result; done = 1 for the DONE cycle only.
- Special cases (b == 0, or signed division with a = −2^(XLEN−1), b = −1) skip RUN:
  - DIV/DIVU by zero → all ones.
  - REM/REMU by zero → a.
  - Overflow DIV → a; overflow REM → 0.
- flush: in any state, the next edge goes to IDLE with done = 0 and result unchanged. flush together with valid_in in IDLE → the op is not accepted.
- valid_in outside IDLE is ignored. The pipeline keeps the instruction in ID/EX through stall, so valid_in stays high and is not re-accepted until DONE returns to IDLE.

## Timing
- Reset (asynchronous, active-low) → state IDLE, counter 0, result 0, done 0, busy 0. stall = valid_in.
- Reset mid-operation → immediate return to IDLE; no done pulse.
- Normal op, accepted at edge 0:
  - RUN occupies cycles 1..XLEN.
  - done is high during cycle XLEN+1.
  - stall is high from the accept cycle through cycle XLEN and low in the DONE cycle, so the pipeline advances on the DONE edge and ID/EX captures result.
- Special-case op: done is high in the cycle after accept, with stall high only in the accept cycle.
- Counter counts 0..XLEN; there is no wrap.
- Back-to-back ops: the earliest next accept is the cycle after DONE, so the minimum spacing is XLEN+2 cycles.

## Test plan
- XLEN=32: MUL a=7, b=−3 → result 0xFFFFFFEB; done pulses exactly at cycle 33 after accept; stall high for cycles 0..32.
- MULH a=0x80000000, b=0x80000000 → 0x40000000. MULHU on the same operands → 0x40000000. MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=−7, b=2 → −3; REM → −1. DIVU a=0xFFFFFFFE, b=3 → 0x55555554; REMU → 2.
- DIVU a=5, b=0 → 0xFFFFFFFF; REM a=5, b=0 → 5; DIV 0x80000000 / −1 → 0x80000000. Each of these gives done one cycle after accept.
- flush at cycle 10 of a DIV → IDLE next cycle, no done, result unchanged. A reset pulse mid-RUN → outputs return to reset values asynchronously.
- XLEN=8 instance: MUL 15×15 → 0xE1; done at cycle 9. valid_in held high through the op causes exactly one accept.
